// File: rtl/pmul_feeder.sv
// Source side of the pmul interface: loads a 3-tap weight set from a serial
// stream, then emits a sliding 3-pixel window per accepted pixel for ROWS rows.
module pmul_feeder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned RW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] s_wgt,
  input  logic             s_wgt_vld,
  output logic             s_wgt_rdy,
  input  logic [WIDTH-1:0] s_pix,
  input  logic             s_pix_vld,
  input  logic             s_pix_last,
  output logic             s_pix_rdy,
  output logic [WIDTH-1:0] in_data2,
  output logic [WIDTH-1:0] in_data1,
  output logic [WIDTH-1:0] in_data0,
  output logic [WIDTH-1:0] in_weight2,
  output logic [WIDTH-1:0] in_weight1,
  output logic [WIDTH-1:0] in_weight0,
  output logic             in_update,
  output logic             win_vld,
  output logic             done,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, LOAD_W, UPDATE, STREAM, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       wgt_idx, wgt_idx_nxt;
  logic [1:0]       fill, fill_nxt, fill_inc;
  logic [RW-1:0]    row_cnt, row_nxt;
  logic [WIDTH-1:0] w2_stg, w2_nxt, w1_stg, w1_nxt;
  logic [WIDTH-1:0] d2_nxt, d1_nxt, d0_nxt;
  logic [WIDTH-1:0] wt2_nxt, wt1_nxt, wt0_nxt;
  logic             upd_nxt, win_nxt, done_nxt;
  logic             wgt_rdy_nxt, pix_rdy_nxt, busy_nxt;
  logic             wgt_xfer, pix_xfer;

  // State and every output register; reset discards any partial job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wgt_idx    <= '0;
      fill       <= '0;
      row_cnt    <= '0;
      w2_stg     <= '0;
      w1_stg     <= '0;
      in_data2   <= '0;
      in_data1   <= '0;
      in_data0   <= '0;
      in_weight2 <= '0;
      in_weight1 <= '0;
      in_weight0 <= '0;
      in_update  <= 1'b0;
      win_vld    <= 1'b0;
      done       <= 1'b0;
      s_wgt_rdy  <= 1'b0;
      s_pix_rdy  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wgt_idx    <= wgt_idx_nxt;
      fill       <= fill_nxt;
      row_cnt    <= row_nxt;
      w2_stg     <= w2_nxt;
      w1_stg     <= w1_nxt;
      in_data2   <= d2_nxt;
      in_data1   <= d1_nxt;
      in_data0   <= d0_nxt;
      in_weight2 <= wt2_nxt;
      in_weight1 <= wt1_nxt;
      in_weight0 <= wt0_nxt;
      in_update  <= upd_nxt;
      win_vld    <= win_nxt;
      done       <= done_nxt;
      s_wgt_rdy  <= wgt_rdy_nxt;
      s_pix_rdy  <= pix_rdy_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state and next-output logic; the ready/busy flags follow the next state
  // so they are valid in the same cycle the FSM enters that state.
  always_comb begin
    state_nxt   = state;
    wgt_idx_nxt = wgt_idx;
    fill_nxt    = fill;
    row_nxt     = row_cnt;
    w2_nxt      = w2_stg;
    w1_nxt      = w1_stg;
    d2_nxt      = in_data2;
    d1_nxt      = in_data1;
    d0_nxt      = in_data0;
    wt2_nxt     = in_weight2;
    wt1_nxt     = in_weight1;
    wt0_nxt     = in_weight0;
    upd_nxt     = 1'b0;
    win_nxt     = 1'b0;
    done_nxt    = 1'b0;
    wgt_xfer    = s_wgt_vld & s_wgt_rdy;
    pix_xfer    = s_pix_vld & s_pix_rdy;
    fill_inc    = (fill == 2'd3) ? 2'd3 : fill + 2'd1;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = LOAD_W;
          wgt_idx_nxt = '0;
          row_nxt     = '0;
        end
      end
      LOAD_W: begin
        if (wgt_xfer) begin
          case (wgt_idx)
            2'd0: begin
              w2_nxt      = s_wgt;
              wgt_idx_nxt = 2'd1;
            end
            2'd1: begin
              w1_nxt      = s_wgt;
              wgt_idx_nxt = 2'd2;
            end
            default: begin
              wt2_nxt     = w2_stg;
              wt1_nxt     = w1_stg;
              wt0_nxt     = s_wgt;
              upd_nxt     = 1'b1;
              wgt_idx_nxt = '0;
              state_nxt   = UPDATE;
            end
          endcase
        end
      end
      UPDATE: begin
        fill_nxt  = '0;
        state_nxt = STREAM;
      end
      STREAM: begin
        if (pix_xfer) begin
          d2_nxt  = in_data1;
          d1_nxt  = in_data0;
          d0_nxt  = s_pix;
          win_nxt = (fill_inc == 2'd3);
          if (s_pix_last) begin
            fill_nxt = '0;
            row_nxt  = row_cnt + RW'(1);
            if (row_nxt == RW'(ROWS)) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end
          end else begin
            fill_nxt = fill_inc;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    wgt_rdy_nxt = (state_nxt == LOAD_W);
    pix_rdy_nxt = (state_nxt == STREAM);
    busy_nxt    = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_pmul_feeder.sv
// Scoreboard bench for pmul_feeder: expected windows are queued at each pixel
// transfer and matched against win_vld/taps on the following falling edge.
module tb_pmul_feeder;

  logic       clk, rst, start;
  logic [7:0] s_wgt, s_pix;
  logic       s_wgt_vld, s_wgt_rdy, s_pix_vld, s_pix_last, s_pix_rdy;
  logic [7:0] in_data2, in_data1, in_data0;
  logic [7:0] in_weight2, in_weight1, in_weight0;
  logic       in_update, win_vld, done, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int win_seen = 0;
  int done_cnt = 0;

  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  logic [7:0]  row_q[$];
  logic [7:0]  md2 = 0, md1 = 0, md0 = 0;
  int          mfill = 0;

  pmul_feeder #(.WIDTH(8), .ROWS(4), .RW(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_wgt(s_wgt), .s_wgt_vld(s_wgt_vld), .s_wgt_rdy(s_wgt_rdy),
    .s_pix(s_pix), .s_pix_vld(s_pix_vld), .s_pix_last(s_pix_last), .s_pix_rdy(s_pix_rdy),
    .in_data2(in_data2), .in_data1(in_data1), .in_data0(in_data0),
    .in_weight2(in_weight2), .in_weight1(in_weight1), .in_weight0(in_weight0),
    .in_update(in_update), .win_vld(win_vld), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every queued window must show up exactly on the next falling edge.
  always @(negedge clk) begin
    if (win_vld === 1'b1) begin
      win_seen++;
      if (exp_q.size() == 0) chk("win_spurious", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("win_taps", {8'd0, in_data2, in_data1, in_data0}, {8'd0, mon_e});
      end
    end else if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("win_missing", {31'd0, win_vld}, 32'd1);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic load_w(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] w [3];
    w[0] = a; w[1] = b; w[2] = c;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("busy_load", {31'd0, busy}, 32'd1);
    s_wgt_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_wgt = w[k];
      chk("wgt_rdy", {31'd0, s_wgt_rdy}, 32'd1);
      @(posedge clk); @(negedge clk);
    end
    chk("wgt_rdy_upd", {31'd0, s_wgt_rdy}, 32'd0);
    chk("upd_pulse", {31'd0, in_update}, 32'd1);
    chk("upd_weights", {8'd0, in_weight2, in_weight1, in_weight0}, {8'd0, a, b, c});
    s_wgt_vld = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("upd_end", {31'd0, in_update}, 32'd0);
    chk("weights_hold", {8'd0, in_weight2, in_weight1, in_weight0}, {8'd0, a, b, c});
    chk("pix_rdy_stream", {31'd0, s_pix_rdy}, 32'd1);
  endtask

  task automatic send_pix(input logic [7:0] p, input logic last, input bit gap);
    if (gap) begin
      s_pix_vld = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    s_pix = p; s_pix_last = last; s_pix_vld = 1'b1;
    chk("pix_rdy", {31'd0, s_pix_rdy}, 32'd1);
    @(posedge clk);
    md2 = md1; md1 = md0; md0 = p;
    if (mfill < 3) mfill++;
    if (mfill == 3) exp_q.push_back({md2, md1, md0});
    if (last) mfill = 0;
    @(negedge clk);
    s_pix_vld = 1'b0; s_pix_last = 1'b0;
  endtask

  task automatic send_row(input bit gap, input bit final_row);
    int n, start_seen, exp_win;
    n = row_q.size();
    start_seen = win_seen;
    exp_win = (n >= 3) ? n - 2 : 0;
    for (int i = 0; i < n; i++) send_pix(row_q[i], (i == n - 1), gap && (i > 0));
    if (final_row) begin
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("busy_in_done", {31'd0, busy}, 32'd1);
      chk("pix_rdy_done", {31'd0, s_pix_rdy}, 32'd0);
    end else begin
      chk("pix_rdy_row_end", {31'd0, s_pix_rdy}, 32'd1);
    end
    @(negedge clk);
    chk("row_win_count", win_seen - start_seen, exp_win);
    if (final_row) begin
      chk("done_end", {31'd0, done}, 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_taps"}, {8'd0, in_data2, in_data1, in_data0}, 32'd0);
    chk({tag, "_wts"}, {8'd0, in_weight2, in_weight1, in_weight0}, 32'd0);
    chk({tag, "_flags"}, {26'd0, in_update, win_vld, done, s_wgt_rdy, s_pix_rdy, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    s_wgt = '0; s_wgt_vld = 1'b0;
    s_pix = '0; s_pix_vld = 1'b0; s_pix_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Job 1: weights 3/4/5, rows 3 (b2b), 5 (gapped), 2, 3.
    load_w(8'd3, 8'd4, 8'd5);
    row_q = '{8'd6, 8'd1, 8'd2};                  send_row(1'b0, 1'b0);
    row_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};      send_row(1'b1, 1'b0);
    row_q = '{8'd7, 8'd8};                        send_row(1'b0, 1'b0);
    row_q = '{8'd9, 8'd10, 8'd11};                send_row(1'b0, 1'b1);
    chk("weights_after_job", {8'd0, in_weight2, in_weight1, in_weight0}, {8'd0, 8'd3, 8'd4, 8'd5});

    // Job 2: row lengths 2,3,5,3.
    load_w(8'd10, 8'd11, 8'd12);
    row_q = '{8'd20, 8'd21};                               send_row(1'b0, 1'b0);
    row_q = '{8'd22, 8'd23, 8'd24};                        send_row(1'b0, 1'b0);
    row_q = '{8'd25, 8'd26, 8'd27, 8'd28, 8'd29};          send_row(1'b1, 1'b0);
    row_q = '{8'd30, 8'd31, 8'd32};                        send_row(1'b0, 1'b1);

    // Job 3: abort with reset two pixels into the second row.
    load_w(8'd1, 8'd1, 8'd1);
    row_q = '{8'd40, 8'd41};                      send_row(1'b0, 1'b0);
    send_pix(8'd42, 1'b0, 1'b0);
    send_pix(8'd43, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_all_zero("midrow_reset");
    rst = 1'b0;
    md2 = 0; md1 = 0; md0 = 0; mfill = 0;
    exp_q.delete();

    load_w(8'd9, 8'd8, 8'd7);
    // start and weight traffic while streaming must be ignored.
    start = 1'b1; s_wgt_vld = 1'b1; s_wgt = 8'd55;
    @(posedge clk); @(negedge clk);
    chk("stray_wgt_rdy", {31'd0, s_wgt_rdy}, 32'd0);
    chk("stray_pix_rdy", {31'd0, s_pix_rdy}, 32'd1);
    chk("stray_update", {31'd0, in_update}, 32'd0);
    chk("stray_weights", {8'd0, in_weight2, in_weight1, in_weight0}, {8'd0, 8'd9, 8'd8, 8'd7});
    start = 1'b0; s_wgt_vld = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("stray_busy", {31'd0, busy}, 32'd1);
    chk("stray_weights2", {8'd0, in_weight2, in_weight1, in_weight0}, {8'd0, 8'd9, 8'd8, 8'd7});
    row_q = '{8'd1, 8'd2, 8'd3};                  send_row(1'b0, 1'b0);

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("done_total", done_cnt, 32'd2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
